seg_display_mux: RTL
====================

Name: seg_display_mux

Overview:
- Parametrised multi-channel hex display scanner for the board's multiplexed common-anode 7-segment display.
- Selects one of NUM_CH debug words (cycle count, PC, address bus, opcode, instruction, state, ...) through `sel` and time-multiplexes its nibbles across NUM_DIGITS digits.
- Latches `sel` and the selected word only at frame boundaries, so a frame never mixes two channels or two samples.
- Sits at the top level between the CPU debug taps and the board pins.

Parameters:
- NUM_DIGITS, 4: number of hex digits; each channel word is 4*NUM_DIGITS bits wide.
- NUM_CH, 6: number of selectable channels.
- REFRESH_DIV, 50000: clk cycles per digit slot, minimum 2.
- SEL_W, $clog2(NUM_CH) (minimum 1): width of `sel`.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_data  in  NUM_CH*4*NUM_DIGITS  flat channel words; channel k is at [k*4*NUM_DIGITS +: 4*NUM_DIGITS].
- sel  in  SEL_W  channel select; sampled only at frame boundaries.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  NUM_DIGITS  digit anodes, active-low, one-hot-low, registered; an[0] is the rightmost digit and shows the least-significant nibble.
- frame_tick  out  1  one-cycle pulse when a new snapshot is loaded.
- sel_err  out  1  high while the last sampled `sel` was out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values:
  - prescaler = 0, digit index = 0, sel_q = 0, snapshot = 0, load_pending = 1.
  - Outputs: an = all ones, seg = 7'h7F, dp = 1, frame_tick = 0, sel_err = 0.
  - Reset asserted mid-frame takes effect on the next edge, overriding everything else.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - `slot_tick` is asserted combinationally while prescaler == REFRESH_DIV-1.
- Digit index:
  - Advances by one on slot_tick.
  - Wraps NUM_DIGITS-1 -> 0.
- Frame boundary (load event): occurs when load_pending == 1, or when slot_tick fires with digit index == NUM_DIGITS-1. On the load edge:
  - If sel < NUM_CH: sel_q <= sel, snapshot <= channel[sel], sel_err <= 0.
  - Otherwise: sel_q and snapshot hold, sel_err <= 1.
  - frame_tick <= 1 for exactly one cycle.
  - load_pending <= 0.
  - The first load therefore happens on the first clk after reset deasserts.
- Output stage:
  - Registered, with one cycle of latency from the internal state.
  - an = ~(1 << digit_index).
  - seg = hex encoding of snapshot nibble [digit_index], active-low:
    - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
    - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
  - dp = ~sel_err, so every decimal point lights while the selection is invalid.
- Changes on `sel` or `ch_data` between load events have no visible effect.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined:
  - Any digit above the most-significant nonzero nibble of the snapshot drives seg = 7'h7F.
  - `an` still scans normally.
  - Digit 0 is never blanked, so a zero word displays a single "0".
  - Blanking is computed from the snapshot, never from live `ch_data`.
- When undefined: every digit shows its nibble, including leading zeros.

Test Plan:
- Bench configuration: NUM_DIGITS=4, NUM_CH=6, REFRESH_DIV=4.
- Reset and first load:
  - Stimulus: hold reset 3 cycles, ch_data ch2=16'hBEEF, sel=2, release reset.
  - Required: frame_tick=1 one cycle after release; next cycle an=4'b1110, seg=7'h0E (F).
  - Then every 4 cycles: an=1101 seg=06, an=1011 seg=06, an=0111 seg=03, and an wraps to 1110.
- Scan/wrap timing:
  - Required: frame_tick pulses exactly every 16 cycles.
  - Required: `an` is never all ones and never has two zeros after the first output update.
- Mid-frame select change:
  - Stimulus: set sel=0 (ch0=16'h1234) at digit 1.
  - Required: digits 2 and 3 still show E and B.
  - Required: after the next frame_tick, digit 0 shows seg=7'h19 (4).
- Out-of-range select:
  - Stimulus: sel=7 at a frame boundary.
  - Required: sel_err=1, dp=0 on all digits, display still shows the previous channel.
  - Stimulus: then sel=0.
  - Required: sel_err=0 and dp=1 after the next frame_tick.
- Reset mid-frame:
  - Stimulus: assert reset at digit 2, prescaler 1.
  - Required: next cycle an=4'hF, seg=7'h7F, frame_tick=0; the scan restarts at digit 0 after release.
- SEG_LEADING_ZERO_BLANK_EN defined:
  - Stimulus: ch0=16'h0050.
  - Required: digits 3 and 2 show seg=7'h7F, digit 1 shows 12 (5), digit 0 shows 40 (0).
  - Stimulus: ch0=16'h0000.
  - Required: only digit 0 shows 40.

Source files
------------

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - multi-channel hex scanner for a multiplexed common-anode 7-segment display
//
// Selects one of NUM_CH debug words with sel and time-multiplexes its nibbles
// across NUM_DIGITS digits. The selection and the word are latched only at
// frame boundaries, so one frame always shows one consistent sample.
//
// Optional macro: SEG_LEADING_ZERO_BLANK_EN blanks the digits above the most
// significant nonzero nibble of the snapshot. Digit 0 is never blanked.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   ch_data    flat channel words, channel k at [k*4*NUM_DIGITS +: 4*NUM_DIGITS]
//   sel        channel select, sampled only at frame boundaries
//   seg        segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         decimal point, active-low, registered (lit while sel_err)
//   an         digit anodes, active-low one-hot, an[0] = rightmost / LS nibble
//   frame_tick one-cycle pulse when a new snapshot is loaded
//   sel_err    high while the last sampled sel was out of range
module seg_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_CH      = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*4*NUM_DIGITS-1:0] ch_data,
    input  logic [SEL_W-1:0]             sel,
    output logic [6:0]                   seg,
    output logic                         dp,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         frame_tick,
    output logic                         sel_err
);

    localparam int WORD_W = 4 * NUM_DIGITS;
    localparam int PRE_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
    // One bit wider than sel so NUM_CH == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);

    logic [PRE_W-1:0]  presc;
    logic [DIG_W-1:0]  digit_idx;
    logic [WORD_W-1:0] snapshot;
    logic              load_pending;

    logic              slot_tick;
    logic              load;
    logic              sel_ok;
    logic [WORD_W-1:0] picked;
    logic [3:0]        nibble;
    logic [6:0]        hex_seg;
    logic [6:0]        seg_next;

    assign slot_tick = (presc == PRE_LAST);
    assign load      = load_pending || (slot_tick && (digit_idx == DIG_LAST));
    assign sel_ok    = ({1'b0, sel} < CH_LIMIT);

    always_comb begin
        picked = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                picked = ch_data[k*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        nibble = 4'h0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_idx == DIG_W'(d)) begin
                nibble = snapshot[d*4 +: 4];
            end
        end
    end

    always_comb begin
        hex_seg = 7'h7F;
        case (nibble)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            4'hF: hex_seg = 7'h0E;
            default: hex_seg = 7'h7F;
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Index of the most significant nonzero nibble; stays 0 for a zero word
    // so the rightmost digit always shows something.
    logic [DIG_W-1:0] msd_idx;

    always_comb begin
        msd_idx = '0;
        for (int d = 1; d < NUM_DIGITS; d++) begin
            if (snapshot[d*4 +: 4] != 4'h0) begin
                msd_idx = DIG_W'(d);
            end
        end
    end

    assign seg_next = (digit_idx > msd_idx) ? 7'h7F : hex_seg;
`else
    assign seg_next = hex_seg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            presc        <= '0;
            digit_idx    <= '0;
            snapshot     <= '0;
            load_pending <= 1'b1;
            frame_tick   <= 1'b0;
            sel_err      <= 1'b0;
            an           <= '1;
            seg          <= 7'h7F;
            dp           <= 1'b1;
        end else begin
            presc <= slot_tick ? '0 : presc + 1'b1;

            if (slot_tick) begin
                digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
            end

            frame_tick <= load;
            if (load) begin
                load_pending <= 1'b0;
                // An invalid select keeps the previous snapshot on screen and
                // only raises the error flag.
                if (sel_ok) begin
                    snapshot <= picked;
                    sel_err  <= 1'b0;
                end else begin
                    sel_err  <= 1'b1;
                end
            end

            an  <= ~(NUM_DIGITS'(1) << digit_idx);
            seg <= seg_next;
            dp  <= ~sel_err;
        end
    end

endmodule
